// File: rtl/chaos_pkg.sv
// Shared types and helpers for the chaos S-box generator: FSM state encoding,
// the sample fold and the table-depth helper.
package chaos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int sbox_depth(input int bw);
    return 1 << bw;
  endfunction

  // XOR of the top and bottom bw bits of a precision-bit sample (zero-extended to 64 bits).
  function automatic logic [15:0] sbox_fold(input logic [63:0] sample, input int precision,
                                            input int bw);
    logic [63:0] mask;
    mask = (64'd1 << bw) - 64'd1;
    return 16'(((sample >> (precision - bw)) ^ sample) & mask);
  endfunction

endpackage

// File: rtl/chaos_sbox_gen_ram.sv
// DEPTH x WIDTH table RAM: one synchronous write port, one registered read port.
// Read is 1-cycle latency, read-before-write on address collision; contents are not reset.
module sbox_ram
  import chaos_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = sbox_depth(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/chaos_sbox_gen.sv
// Builds a bijective 2^BIT_WIDTH S-box from folded chaotic samples, resolving collisions by
// linear probing; s_tready only in FETCH. Optional inverse table under `INV_SBOX_EN.
module chaos_sbox_gen
  import chaos_pkg::*;
#(
  parameter int PRECISION = 32,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [PRECISION-1:0] s_tdata,
  output logic                 busy,
  output logic                 done_sbox,
  input  logic [BIT_WIDTH-1:0] rd_addr,
  output logic [BIT_WIDTH-1:0] rd_data
`ifdef INV_SBOX_EN
  ,
  input  logic [BIT_WIDTH-1:0] inv_rd_addr,
  output logic [BIT_WIDTH-1:0] inv_rd_data
`endif
);

  localparam int DEPTH = sbox_depth(BIT_WIDTH);
  localparam logic [BIT_WIDTH:0] LAST_IDX = {1'b0, {BIT_WIDTH{1'b1}}};

  state_t                 state;
  state_t                 state_nxt;
  logic [DEPTH-1:0]       used;
  logic [BIT_WIDTH:0]     idx;
  logic [BIT_WIDTH-1:0]   cand;
  logic                   clear;
  logic                   accept;
  logic                   slot_free;
  logic                   wr_en;

  assign accept    = s_tready && s_tvalid;
  assign slot_free = !used[cand];
  assign wr_en     = (state == PROBE) && slot_free && !reset;

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    busy      = 1'b0;
    done_sbox = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        s_tready = 1'b1;
        busy     = 1'b1;
        if (s_tvalid) begin
          state_nxt = PROBE;
        end
      end
      PROBE: begin
        busy = 1'b1;
        if (slot_free) begin
          state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
        end
      end
      DONE: begin
        done_sbox = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      used  <= '0;
      idx   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        used <= '0;
        idx  <= '0;
      end
      if (accept) begin
        cand <= BIT_WIDTH'(sbox_fold(64'(s_tdata), PRECISION, BIT_WIDTH));
      end
      // Occupied slot: step to the next candidate, wrapping at the table end.
      if (wr_en) begin
        used[cand] <= 1'b1;
        idx        <= idx + (BIT_WIDTH + 1)'(1);
      end else if (state == PROBE) begin
        cand <= cand + BIT_WIDTH'(1);
      end
    end
  end

  sbox_ram #(.WIDTH(BIT_WIDTH)) u_fwd_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_addr (idx[BIT_WIDTH-1:0]),
    .wr_data (cand),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef INV_SBOX_EN
  sbox_ram #(.WIDTH(BIT_WIDTH)) u_inv_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_addr (cand),
    .wr_data (idx[BIT_WIDTH-1:0]),
    .rd_addr (inv_rd_addr),
    .rd_data (inv_rd_data)
  );
`endif

endmodule

// File: tb/tb_chaos_sbox_gen.sv
// Directed bench for chaos_sbox_gen: a 8/4 instance for hand-computed tables and timing,
// and a default 32/8 instance for a stalled LFSR stream, abort and restart.
module tb_chaos_sbox_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_s, tvalid_s, tready_s, busy_s, done_s;
  logic [7:0] tdata_s;
  logic [3:0] rd_addr_s, rd_data_s;
  logic       start_l, tvalid_l, tready_l, busy_l, done_l;
  logic [31:0] tdata_l;
  logic [7:0] rd_addr_l, rd_data_l;
`ifdef INV_SBOX_EN
  logic [3:0] inv_addr_s, inv_data_s;
  logic [7:0] inv_addr_l, inv_data_l;
`endif

  chaos_sbox_gen #(.PRECISION(8), .BIT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .s_tvalid(tvalid_s), .s_tready(tready_s),
    .s_tdata(tdata_s), .busy(busy_s), .done_sbox(done_s), .rd_addr(rd_addr_s),
    .rd_data(rd_data_s)
`ifdef INV_SBOX_EN
    , .inv_rd_addr(inv_addr_s), .inv_rd_data(inv_data_s)
`endif
  );

  chaos_sbox_gen #(.PRECISION(32), .BIT_WIDTH(8)) dut_l (
    .clk(clk), .reset(reset), .start(start_l), .s_tvalid(tvalid_l), .s_tready(tready_l),
    .s_tdata(tdata_l), .busy(busy_l), .done_sbox(done_l), .rd_addr(rd_addr_l),
    .rd_data(rd_data_l)
`ifdef INV_SBOX_EN
    , .inv_rd_addr(inv_addr_l), .inv_rd_data(inv_data_l)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  vec_s  [16];
  logic [3:0]  exp_s  [16];
  logic [31:0] stream [256];
  logic [7:0]  exp_l  [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one generation on the small instance; cyc counts edges from FETCH entry to done.
  task automatic run_s(input int pulse_at, output int cyc, output int hs);
    logic fire;
    start_s = 1'b1;
    tick();
    start_s  = 1'b0;
    check("s_busy_after_start", busy_s, 1);
    check("s_done_after_start", done_s, 0);
    tvalid_s = 1'b1;
    tdata_s  = vec_s[0];
    cyc = 0;
    hs  = 0;
    while (!done_s && cyc < 2000) begin
      fire    = tvalid_s && tready_s;
      start_s = (cyc == pulse_at);
      tick();
      cyc++;
      if (fire) hs++;
      tdata_s = (hs < 16) ? vec_s[hs] : 8'hAA;
    end
    start_s = 1'b0;
    if (!done_s) check("s_run_timeout", done_s, 1);
    repeat (4) begin
      fire = tvalid_s && tready_s;
      tick();
      if (fire) hs++;
    end
    tvalid_s = 1'b0;
    check("s_done_level", done_s, 1);
    check("s_busy_done", busy_s, 0);
    check("s_tready_done", tready_s, 0);
  endtask

  task automatic check_table_s(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr_s = 4'(i);
      tick();
      check($sformatf("%s[%0d]", tag, i), rd_data_s, exp_s[i]);
    end
  endtask

  // Large instance with random valid gaps; stops early once abort_at samples are accepted.
  task automatic run_l(input int abort_at, output int cyc, output int hs);
    logic fire;
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    tvalid_l = 1'b0;
    cyc = 0;
    hs  = 0;
    while (!done_l && cyc < 40000 && !(abort_at >= 0 && hs >= abort_at)) begin
      fire = tvalid_l && tready_l;
      tick();
      cyc++;
      if (fire) hs++;
      tvalid_l = ($urandom_range(0, 3) != 0);
      tdata_l  = (tvalid_l && hs < 256) ? stream[hs] : $urandom();
    end
    if (cyc >= 40000) check("l_run_timeout", done_l, 1);
  endtask

  initial begin
    int cyc, hs, fires, bad, distinct;
    logic [31:0] x;
    logic [7:0]  c;
    logic [255:0] taken;
    logic [255:0] seen;
    logic [3:0]  v;

    reset = 1'b1;
    start_s = 0; tvalid_s = 0; tdata_s = '0; rd_addr_s = '0;
    start_l = 0; tvalid_l = 0; tdata_l = '0; rd_addr_l = '0;
`ifdef INV_SBOX_EN
    inv_addr_s = '0; inv_addr_l = '0;
`endif
    repeat (3) tick();
    check("rst_s_tready", tready_s, 0);
    check("rst_s_busy", busy_s, 0);
    check("rst_s_done", done_s, 0);
    check("rst_s_rd_data", rd_data_s, 0);
    check("rst_l_tready", tready_l, 0);
    check("rst_l_busy", busy_l, 0);
    check("rst_l_done", done_l, 0);
    check("rst_l_rd_data", rd_data_l, 0);
`ifdef INV_SBOX_EN
    check("rst_l_inv_data", inv_data_l, 0);
`endif

    start_s = 1'b1; start_l = 1'b1; tvalid_s = 1'b1;
    tick();
    reset = 1'b0; start_s = 1'b0; start_l = 1'b0;
    tick();
    check("start_in_rst_busy", busy_s, 0);
    check("start_in_rst_tready", tready_s, 0);
    check("start_in_rst_l_busy", busy_l, 0);
    tvalid_s = 1'b0;

    // Best case: fold(0x0i) = i, with a start pulse mid-run that must be ignored.
    for (int i = 0; i < 16; i++) begin
      vec_s[i] = 8'(i);
      exp_s[i] = 4'(i);
    end
    run_s(10, cyc, hs);
    check("best_cycles", cyc, 32);
    check("best_handshakes", hs, 16);
    check_table_s("best");

    // All samples fold to 0: entry i probes past i used slots.
    for (int i = 0; i < 16; i++) vec_s[i] = 8'h00;
    run_s(-1, cyc, hs);
    check("ident_cycles", cyc, 32 + 120);
    check("ident_handshakes", hs, 16);
    check_table_s("ident");

    // Everything folds to F: entry 0 takes F, later entries wrap to 0,1,...
    vec_s[0] = 8'h0F;
    for (int i = 1; i < 16; i++) vec_s[i] = 8'hF0;
    exp_s[0] = 4'hF;
    for (int i = 1; i < 16; i++) exp_s[i] = 4'(i - 1);
    run_s(-1, cyc, hs);
    check("wrap_handshakes", hs, 16);
    check_table_s("wrap");

    // Both fold halves nonzero: {3, 3^v} folds to v, giving a reversed table.
    for (int i = 0; i < 16; i++) begin
      v = 4'(15 - i);
      vec_s[i] = {4'h3, v ^ 4'h3};
      exp_s[i] = v;
    end
    run_s(-1, cyc, hs);
    check("rev_cycles", cyc, 32);
    check_table_s("rev");

    x = 32'h1234_5678;
    taken = '0;
    for (int n = 0; n < 256; n++) begin
      x ^= x << 13;
      x ^= x >> 17;
      x ^= x << 5;
      stream[n] = x;
      c = x[31:24] ^ x[7:0];
      while (taken[c]) c = c + 8'd1;
      taken[c] = 1'b1;
      exp_l[n] = c;
    end

    run_l(-1, cyc, hs);
    fires = 0;
    tvalid_l = 1'b1;
    repeat (4) begin
      if (tvalid_l && tready_l) fires++;
      tick();
    end
    tvalid_l = 1'b0;
    check("l_handshakes", hs + fires, 256);
    check("l_done", done_l, 1);
    check("l_busy_done", busy_l, 0);
    seen = '0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd_addr_l = 8'(i);
      tick();
      seen[rd_data_l] = 1'b1;
      if (rd_data_l !== exp_l[i]) bad++;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("l_permutation", distinct, 256);
    check("l_table_vs_model", bad, 0);
`ifdef INV_SBOX_EN
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      inv_addr_l = exp_l[i];
      tick();
      if (inv_data_l !== 8'(i)) bad++;
    end
    check("l_inverse", bad, 0);
`endif

    // Abort after 100 accepted samples, then rerun the same stream from scratch.
    run_l(100, cyc, hs);
    check("abort_reached", hs, 100);
    reset = 1'b1;
    tvalid_l = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_done", done_l, 0);
    check("abort_busy", busy_l, 0);
    check("abort_tready", tready_l, 0);
    fires = 0;
    repeat (3) begin
      if (tvalid_l && tready_l) fires++;
      tick();
    end
    check("abort_idle_fires", fires, 0);
    check("abort_still_idle", busy_l, 0);
    tvalid_l = 1'b0;

    run_l(-1, cyc, hs);
    check("restart_handshakes", hs, 256);
    check("restart_done", done_l, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd_addr_l = 8'(i);
      tick();
      if (rd_data_l !== exp_l[i]) bad++;
    end
    check("restart_table", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chaos_sbox_gen.md
# chaos_sbox_gen

Parametrised S-box generator for the chaos-based image cipher. It consumes PRECISION-bit chaotic samples from the upstream PRNG over a valid/ready stream and folds each sample to a BIT_WIDTH-bit candidate. Duplicates are resolved by linear probing, so the block always builds a bijective 2^BIT_WIDTH-entry substitution table in bounded time. The finished table is readable by the substitution stage through a registered read port, and an inverse table for decryption can optionally be built alongside it.

## Interface
Parameters:
- PRECISION, 32, width of each chaotic sample; must satisfy PRECISION >= 2*BIT_WIDTH
- BIT_WIDTH, 8, S-box symbol width; table depth DEPTH = 2^BIT_WIDTH (derived, not overridable)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins generation from IDLE or DONE
- s_tvalid  in  1  upstream sample valid
- s_tready  out  1  block ready to accept a sample
- s_tdata  in  PRECISION  chaotic sample
- busy  out  1  high while generation is in progress
- done_sbox  out  1  table complete; level output
- rd_addr  in  BIT_WIDTH  forward-table read address
- rd_data  out  BIT_WIDTH  forward-table data, 1-cycle latency

## Operation
- Fold: cand = s_tdata[PRECISION-1 -: BIT_WIDTH] ^ s_tdata[BIT_WIDTH-1:0].
- State is a DEPTH-bit used bitmap, an entry index idx (BIT_WIDTH+1 bits) and a candidate register cand.
- IDLE: s_tready=0, busy=0. On start: bitmap cleared, idx=0, done_sbox=0, next state FETCH.
- FETCH: s_tready=1, busy=1. On s_tvalid && s_tready: cand <= fold(s_tdata), next state PROBE. Otherwise stay in FETCH.
- PROBE: s_tready=0, busy=1.
  - If used[cand]==0: sbox[idx] <= cand; used[cand] <= 1; idx <= idx+1. Next state is DONE if idx==DEPTH-1, else FETCH.
  - Else: cand <= cand+1 modulo DEPTH (wraps from DEPTH-1 to 0); stay in PROBE.
- DONE: done_sbox=1, busy=0, s_tready=0. start re-enters the clear/FETCH path with the same effect as from IDLE.
- start is ignored while in FETCH or PROBE.
- Samples are never consumed outside FETCH. Exactly DEPTH samples are consumed per generation.
- Read port: rd_data <= sbox[rd_addr] every cycle. Reads during generation return partially written or stale contents.

## Timing
- Reset values: s_tready=0, busy=0, done_sbox=0, rd_data=0, state=IDLE. Table RAM is not reset.
- start sampled at edge k, so busy=1 and s_tready=1 from cycle k+1.
- Each entry costs 1 accept cycle + 1 PROBE cycle + p extra PROBE cycles, where p is the number of occupied slots skipped (p <= DEPTH-1).
- Best-case total with s_tvalid held high is 2*DEPTH cycles from FETCH entry to DONE.
- done_sbox rises on the edge that writes the last entry and stays high until the next start or reset.
- Reset asserted mid-generation aborts to IDLE on that edge. No further samples are accepted, and done_sbox stays 0.
- rd_data reflects a write to the same address issued on the same edge only on the following cycle (read-before-write).

## Configuration
- INV_SBOX_EN defined:
  - Adds inverse-table ports inv_rd_addr (in, BIT_WIDTH) and inv_rd_data (out, BIT_WIDTH, 1-cycle latency, reset value 0).
  - The PROBE write also performs inv[cand] <= idx[BIT_WIDTH-1:0].
  - After DONE, inv[sbox[i]] == i for all i.
- INV_SBOX_EN undefined: no inverse RAM and no inverse ports. Forward behaviour and timing are identical.

## Structure
- Shared package chaos_pkg holds:
  - the state enum (IDLE, FETCH, PROBE, DONE);
  - the sbox_fold function;
  - a DEPTH helper function of BIT_WIDTH.
- Sub-module sbox_ram: a DEPTH x BIT_WIDTH RAM with one synchronous write port and one registered read port. It is instantiated once for the forward table and once more under INV_SBOX_EN.
- The bitmap, FSM and probe logic stay in chaos_sbox_gen.

## Test plan
- Reset check: hold reset 3 cycles → all outputs 0. Assert start during reset → still IDLE on release.
- Identity case, PRECISION=8, BIT_WIDTH=4, s_tdata=0x00 always:
  - sbox[i]==i for i=0..15.
  - Entry i takes i extra PROBE cycles.
  - done_sbox after 32+120 cycles.
- Best case, PRECISION=8, BIT_WIDTH=4, s_tdata=0x0i for i=0..15 (fold = i):
  - Identity table.
  - done_sbox exactly 32 cycles after FETCH entry.
  - 16 handshakes counted.
- Wrap-around: BIT_WIDTH=4, first sample folds to 0xF, all later samples fold to 0xF → sbox = {F,0,1,...,E}, exercising cand wrap from F to 0.
- Backpressure: default parameters, random LFSR samples with random s_tvalid gaps.
  - Table is a permutation of 0..255.
  - No sample is accepted while s_tready=0.
  - With INV_SBOX_EN, inv[sbox[i]]==i for all i.
- Abort and restart:
  - Assert reset at entry 100 → done_sbox=0, idle.
  - New start with the same sample stream → identical table to a clean run.
  - start pulsed mid-run → ignored.
